// File: rtl/seanetnackgenerator_ddr_bmp_rmw_if.sv
// Bus bundle for the bitmap read-modify-write engine: command stream in, DDR read/write ports out.
// Signal names keep the direction prefixes as seen from the engine.
interface seanetnackgenerator_ddr_bmp_rmw_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 512
);
  logic [ADDR_W-1:0] i_ddr_cmd_addr;
  logic [DATA_W-1:0] i_ddr_cmd_data;
  logic [7:0]        i_ddr_cmd_len;
  logic [1:0]        i_ddr_cmd_type;
  logic              i_ddr_cmd_valid;
  logic              i_ddr_cmd_ready;

  logic [ADDR_W-1:0] o_rd_req_addr;
  logic              o_rd_req_valid;
  logic              i_rd_req_ready;

  logic [DATA_W-1:0] i_rd_rsp_data;
  logic              i_rd_rsp_valid;
  logic              o_rd_rsp_ready;

  logic [ADDR_W-1:0] o_wr_req_addr;
  logic [DATA_W-1:0] o_wr_req_data;
  logic              o_wr_req_valid;
  logic              i_wr_req_ready;

  // Engine side
  modport slave (
    input  i_ddr_cmd_addr, i_ddr_cmd_data, i_ddr_cmd_len, i_ddr_cmd_type, i_ddr_cmd_valid,
    output i_ddr_cmd_ready,
    output o_rd_req_addr, o_rd_req_valid,
    input  i_rd_req_ready,
    input  i_rd_rsp_data, i_rd_rsp_valid,
    output o_rd_rsp_ready,
    output o_wr_req_addr, o_wr_req_data, o_wr_req_valid,
    input  i_wr_req_ready
  );

  // Command source / DDR controller side
  modport master (
    output i_ddr_cmd_addr, i_ddr_cmd_data, i_ddr_cmd_len, i_ddr_cmd_type, i_ddr_cmd_valid,
    input  i_ddr_cmd_ready,
    input  o_rd_req_addr, o_rd_req_valid,
    output i_rd_req_ready,
    output i_rd_rsp_data, i_rd_rsp_valid,
    input  o_rd_rsp_ready,
    input  o_wr_req_addr, o_wr_req_data, o_wr_req_valid,
    output i_wr_req_ready
  );
endinterface

// File: rtl/seanetnackgenerator_ddr_bmp_rmw.sv
// Bitmap line read-modify-write: reads one DDR line, sets/clears masked bits, writes back only if changed.
// One command in flight; status and event counters exposed on dfx_sta0..3.
module seanetnackgenerator_ddr_bmp_rmw #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 512,
  parameter int RD_TIMEOUT = 1024
) (
  input  logic                              sys_clk,
  input  logic                              sys_rst_n,
  seanetnackgenerator_ddr_bmp_rmw_if.slave  bus,
  output logic [31:0]                       dfx_sta0,
  output logic [31:0]                       dfx_sta1,
  output logic [31:0]                       dfx_sta2,
  output logic [31:0]                       dfx_sta3
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_REQ  = 3'd1,
    RD_WAIT = 3'd2,
    MODIFY  = 3'd3,
    WR_REQ  = 3'd4
  } state_t;

  localparam int TMO_W = $clog2(RD_TIMEOUT + 1);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] mask_q, mask_d;
  logic [DATA_W-1:0] old_q, old_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  logic              type_set_q, type_set_d;
  logic [TMO_W-1:0]  tmo_ctr_q, tmo_ctr_d;

  logic              cmd_ready_q, cmd_ready_d;
  logic              rd_req_valid_q, rd_req_valid_d;
  logic              rd_rsp_ready_q, rd_rsp_ready_d;
  logic              wr_req_valid_q, wr_req_valid_d;

  logic [31:0]       done_cnt_q, done_cnt_d;
  logic [15:0]       skip_cnt_q, skip_cnt_d;
  logic [15:0]       len_cnt_q, len_cnt_d;
  logic [15:0]       tmo_cnt_q, tmo_cnt_d;
  logic [15:0]       ill_cnt_q, ill_cnt_d;
  logic [15:0]       stray_cnt_q, stray_cnt_d;

  logic              cmd_fire;
  logic              rd_req_fire;
  logic              rsp_fire;
  logic              wr_fire;
  logic              tmo_hit;
  logic              line_same;
  logic [DATA_W-1:0] new_line;

  assign cmd_fire    = bus.i_ddr_cmd_valid & cmd_ready_q;
  assign rd_req_fire = rd_req_valid_q & bus.i_rd_req_ready;
  assign rsp_fire    = bus.i_rd_rsp_valid & rd_rsp_ready_q;
  assign wr_fire     = wr_req_valid_q & bus.i_wr_req_ready;
  assign tmo_hit     = (tmo_ctr_q == TMO_W'(RD_TIMEOUT - 1));

  generate
    for (genvar gi = 0; gi < DATA_W; gi++) begin : g_modify
      assign new_line[gi] = type_set_q ? (old_q[gi] | mask_q[gi]) : (old_q[gi] & ~mask_q[gi]);
    end
  endgenerate

  assign line_same = (new_line == old_q);

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    mask_d      = mask_q;
    old_d       = old_q;
    wr_data_d   = wr_data_q;
    type_set_d  = type_set_q;
    tmo_ctr_d   = tmo_ctr_q;
    done_cnt_d  = done_cnt_q;
    skip_cnt_d  = skip_cnt_q;
    len_cnt_d   = len_cnt_q;
    tmo_cnt_d   = tmo_cnt_q;
    ill_cnt_d   = ill_cnt_q;
    stray_cnt_d = stray_cnt_q;

    case (state_q)
      IDLE: begin
        if (cmd_fire) begin
          addr_d     = bus.i_ddr_cmd_addr;
          mask_d     = bus.i_ddr_cmd_data;
          type_set_d = bus.i_ddr_cmd_type[0];
          if (bus.i_ddr_cmd_type[1]) begin
            ill_cnt_d = ill_cnt_q + 16'd1;
          end else begin
            state_d = RD_REQ;
            if (bus.i_ddr_cmd_len != 8'd0) begin
              len_cnt_d = len_cnt_q + 16'd1;
            end
          end
        end
        // Late responses that arrive after a timeout are drained here
        if (rsp_fire) begin
          stray_cnt_d = stray_cnt_q + 16'd1;
        end
      end
      RD_REQ: begin
        if (rd_req_fire) begin
          state_d   = RD_WAIT;
          tmo_ctr_d = '0;
        end
      end
      RD_WAIT: begin
        // A response in the final timeout cycle still wins over the abort
        if (rsp_fire) begin
          old_d   = bus.i_rd_rsp_data;
          state_d = MODIFY;
        end else if (tmo_hit) begin
          tmo_cnt_d = tmo_cnt_q + 16'd1;
          state_d   = IDLE;
        end else begin
          tmo_ctr_d = tmo_ctr_q + 1'b1;
        end
      end
      MODIFY: begin
        if (line_same) begin
          skip_cnt_d = skip_cnt_q + 16'd1;
          done_cnt_d = done_cnt_q + 32'd1;
          state_d    = IDLE;
        end else begin
          wr_data_d = new_line;
          state_d   = WR_REQ;
        end
      end
      WR_REQ: begin
        if (wr_fire) begin
          done_cnt_d = done_cnt_q + 32'd1;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Handshake outputs are registered from the next state so they are glitch-free and low in reset
    cmd_ready_d    = (state_d == IDLE);
    rd_req_valid_d = (state_d == RD_REQ);
    rd_rsp_ready_d = (state_d == IDLE) || (state_d == RD_WAIT);
    wr_req_valid_d = (state_d == WR_REQ);
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q        <= IDLE;
      addr_q         <= '0;
      mask_q         <= '0;
      old_q          <= '0;
      wr_data_q      <= '0;
      type_set_q     <= 1'b0;
      tmo_ctr_q      <= '0;
      cmd_ready_q    <= 1'b0;
      rd_req_valid_q <= 1'b0;
      rd_rsp_ready_q <= 1'b0;
      wr_req_valid_q <= 1'b0;
      done_cnt_q     <= '0;
      skip_cnt_q     <= '0;
      len_cnt_q      <= '0;
      tmo_cnt_q      <= '0;
      ill_cnt_q      <= '0;
      stray_cnt_q    <= '0;
    end else begin
      state_q        <= state_d;
      addr_q         <= addr_d;
      mask_q         <= mask_d;
      old_q          <= old_d;
      wr_data_q      <= wr_data_d;
      type_set_q     <= type_set_d;
      tmo_ctr_q      <= tmo_ctr_d;
      cmd_ready_q    <= cmd_ready_d;
      rd_req_valid_q <= rd_req_valid_d;
      rd_rsp_ready_q <= rd_rsp_ready_d;
      wr_req_valid_q <= wr_req_valid_d;
      done_cnt_q     <= done_cnt_d;
      skip_cnt_q     <= skip_cnt_d;
      len_cnt_q      <= len_cnt_d;
      tmo_cnt_q      <= tmo_cnt_d;
      ill_cnt_q      <= ill_cnt_d;
      stray_cnt_q    <= stray_cnt_d;
    end
  end

  assign bus.i_ddr_cmd_ready = cmd_ready_q;
  assign bus.o_rd_req_addr   = addr_q;
  assign bus.o_rd_req_valid  = rd_req_valid_q;
  assign bus.o_rd_rsp_ready  = rd_rsp_ready_q;
  assign bus.o_wr_req_addr   = addr_q;
  assign bus.o_wr_req_data   = wr_data_q;
  assign bus.o_wr_req_valid  = wr_req_valid_q;

  assign dfx_sta0 = done_cnt_q;
  assign dfx_sta1 = {skip_cnt_q, len_cnt_q};
  assign dfx_sta2 = {tmo_cnt_q, ill_cnt_q};
  assign dfx_sta3 = {stray_cnt_q, 13'd0, state_q};

endmodule
